// File: rtl/fila_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fila_pkg
// Description : Shared types and constants for the fila byte-queue drain
//               stage (serializer FSM states, frame levels, data width).
// Revision    : 1.0 - initial release
// ============================================================================
package fila_pkg;

  // Serializer FSM states; explicit 3-bit encoding keeps the register width fixed
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } ser_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage : fila_pkg
`default_nettype wire

// File: rtl/fila_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : fila_bit_timer
// Description : Serial bit-period timer. Counts CLKS_PER_BIT cycles and
//               raises bit_done on the last cycle of each bit period. The
//               counter reloads to zero on bit_done or when cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module fila_bit_timer
  import fila_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] tick_count;

  assign bit_done = (tick_count == LAST_TICK);

  // Tick counter: restart at each state entry and at every bit boundary
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_count <= '0;
    end else if (clear || bit_done) begin
      tick_count <= '0;
    end else begin
      tick_count <= tick_count + 1'b1;
    end
  end

endmodule : fila_bit_timer
`default_nettype wire

// File: rtl/fila_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fila_serializer
// Description : Drain stage for the fila byte queue. Pops one byte at a time
//               (single-cycle deq_out pulse), then sends it on tx_out as
//               start bit, 8 data bits LSB first, optional even parity and
//               stop bit. Counts completed frames modulo 256.
//               Build option: define FILA_SER_PARITY_EN to add the parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module fila_serializer
  import fila_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable_in,
  input  logic [7:0] len_in,
  input  logic [7:0] data_in,
  output logic       deq_out,
  output logic       tx_out,
  output logic       busy_out,
  output logic [7:0] sent_count_out
);

  ser_state_t state;
  ser_state_t state_next;

  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [2:0]           bit_idx;
  logic [2:0]           bit_idx_next;
  logic [7:0]           count_next;
  logic                 tx_next;
  logic                 deq_next;
  logic                 busy_next;

  logic bit_done;
  logic timer_clear;
  logic frame_ok;
  logic last_data_bit;

  // A new frame may start only when allowed and the queue is not empty
  assign frame_ok      = enable_in && (len_in != 8'd0);
  assign last_data_bit = (bit_idx == 3'(DATA_BITS - 1));

  // Every state change restarts the bit period so each state gets full bits
  assign timer_clear = (state_next != state);

  fila_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear),
    .bit_done (bit_done)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a frame in progress always runs to its stop bit
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (frame_ok) state_next = S_REQ;
      S_REQ:   state_next = S_WAIT;
      S_WAIT:  state_next = S_START;
      S_START: if (bit_done) state_next = S_DATA;
      S_DATA: begin
        if (bit_done && last_data_bit) begin
`ifdef FILA_SER_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef FILA_SER_PARITY_EN
      S_PARITY: if (bit_done) state_next = S_STOP;
`endif
      S_STOP:  if (bit_done) state_next = frame_ok ? S_REQ : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output and datapath next values, derived from the next state so that the
  // registered outputs line up with the state they belong to
  always_comb begin
    shift_next   = shift_reg;
    bit_idx_next = bit_idx;
    count_next   = sent_count_out;

    // The queue's registered head is valid during WAIT
    if (state == S_WAIT) begin
      shift_next = data_in;
    end

    // Rotate rather than shift so the full byte survives for the parity bit
    if ((state == S_DATA) && bit_done) begin
      shift_next   = {shift_reg[0], shift_reg[DATA_BITS-1:1]};
      bit_idx_next = bit_idx + 3'd1;
    end

    if ((state == S_STOP) && bit_done) begin
      count_next = sent_count_out + 8'd1;
    end

    deq_next  = (state_next == S_REQ);
    busy_next = (state_next != S_IDLE);

    case (state_next)
      S_START:  tx_next = START_LEVEL;
      S_DATA:   tx_next = shift_next[0];
`ifdef FILA_SER_PARITY_EN
      S_PARITY: tx_next = ^shift_reg;
`endif
      default:  tx_next = IDLE_LEVEL;
    endcase
  end

  // Output and datapath registers; reset drops any popped byte in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_out         <= IDLE_LEVEL;
      deq_out        <= 1'b0;
      busy_out       <= 1'b0;
      sent_count_out <= 8'd0;
      shift_reg      <= '0;
      bit_idx        <= 3'd0;
    end else begin
      tx_out         <= tx_next;
      deq_out        <= deq_next;
      busy_out       <= busy_next;
      sent_count_out <= count_next;
      shift_reg      <= shift_next;
      bit_idx        <= bit_idx_next;
    end
  end

endmodule : fila_serializer
`default_nettype wire

// File: tb/tb_fila_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fila_serializer
// Description : Directed self-checking bench for fila_serializer with a small
//               behavioural model of the upstream fila queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fila_serializer;

  localparam int C = 4;
`ifdef FILA_SER_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable_in = 1'b0;
  logic [7:0] len_in;
  logic [7:0] data_in = 8'd0;
  logic       deq_out;
  logic       tx_out;
  logic       busy_out;
  logic [7:0] sent_count_out;

  int checks = 0;
  int errors = 0;

  fila_serializer #(
    .CLKS_PER_BIT (C)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable_in      (enable_in),
    .len_in         (len_in),
    .data_in        (data_in),
    .deq_out        (deq_out),
    .tx_out         (tx_out),
    .busy_out       (busy_out),
    .sent_count_out (sent_count_out)
  );

  always #5 clock = ~clock;

  // Upstream queue model: registered head output updated by each pop
  logic [7:0] qmem [0:63];
  int head = 0;
  int tail = 0;
  assign len_in = 8'(tail - head);

  always @(posedge clock) begin
    if (deq_out === 1'b1) begin
      data_in <= qmem[head];
      head    <= head + 1;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int deq_cnt = 0;
  int last_deq_cyc = 0;
  int pop_empty = 0;
  always @(negedge clock) begin
    if (deq_out === 1'b1) begin
      deq_cnt = deq_cnt + 1;
      last_deq_cyc = cyc;
      if (len_in == 8'd0) pop_empty = pop_empty + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    qmem[tail] = b;
    tail = tail + 1;
  endtask

  // Wait for a start bit, then capture one bit value per bit period;
  // fr[i] is the i-th bit on the line in time order
  task automatic rx_frame(input int drop_at, output logic [10:0] fr,
                          output logic stable, output int start_cyc,
                          output logic [7:0] cnt_last, output logic ok);
    logic v;
    fr = '0; stable = 1'b1; ok = 1'b0; start_cyc = 0; cnt_last = 8'd0; v = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (tx_out === 1'b0) ok = 1'b1;
      else @(negedge clock);
    end
    if (ok) begin
      start_cyc = cyc;
      for (int i = 0; i < NBITS; i++) begin
        for (int c = 0; c < C; c++) begin
          if (drop_at == i * C + c) enable_in = 1'b0;
          if (c == 0) v = tx_out;
          else if (tx_out !== v) stable = 1'b0;
          if (i == NBITS - 1 && c == C - 1) cnt_last = sent_count_out;
          @(negedge clock);
        end
        fr[i] = v;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0;
    enable_in = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_out); end
    checks++; if (deq_out !== 1'b0) begin errors++; $display("FAIL reset_deq got %b want 0", deq_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_out); end
    checks++; if (sent_count_out !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sent_count_out); end
    reset = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (tx_out !== 1'b1 || deq_out !== 1'b0 || busy_out !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_empty_queue active_cycles %0d want 0", bad); end
  endtask

  task automatic test_single();
    logic [10:0] fr; logic st; int sc; logic [7:0] cl; logic ok; int d0;
    logic [10:0] exp_fr;
`ifdef FILA_SER_PARITY_EN
    exp_fr = 11'h54A;
`else
    exp_fr = 11'h34A;
`endif
    d0 = deq_cnt;
    push(8'hA5);
    rx_frame(-1, fr, st, sc, cl, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_start_timeout got %b want 1", ok); end
    checks++; if (fr !== exp_fr) begin errors++; $display("FAIL single_line_seq got %h want %h", fr, exp_fr); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL single_bit_hold got %b want 1", st); end
    checks++; if (sc - last_deq_cyc != 2) begin errors++; $display("FAIL single_deq_to_start got %0d want 2", sc - last_deq_cyc); end
    repeat (3) @(negedge clock);
    checks++; if (deq_cnt - d0 != 1) begin errors++; $display("FAIL single_deq_pulses got %0d want 1", deq_cnt - d0); end
    checks++; if (sent_count_out !== 8'd1) begin errors++; $display("FAIL single_count got %0d want 1", sent_count_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy_out); end
  endtask

  task automatic test_parity();
    logic [10:0] fr; logic st; int sc; logic [7:0] cl; logic ok; logic [7:0] c0;
    logic [10:0] exp_fr;
`ifdef FILA_SER_PARITY_EN
    exp_fr = 11'h602;
`else
    exp_fr = 11'h202;
`endif
    c0 = sent_count_out;
    push(8'h01);
    rx_frame(-1, fr, st, sc, cl, ok);
    checks++; if (ok !== 1'b1 || fr !== exp_fr) begin errors++; $display("FAIL parity_frame got %h want %h", fr, exp_fr); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL parity_bit_hold got %b want 1", st); end
    // Count still old on the last stop cycle and new one cycle later pins the frame length
    checks++; if (cl !== c0 || sent_count_out !== 8'(c0 + 8'd1)) begin
      errors++; $display("FAIL parity_frame_len count_last %0d count_after %0d want %0d then %0d", cl, sent_count_out, c0, c0 + 8'd1);
    end
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL parity_after_tx got %b want 1", tx_out); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] fr; logic st; int sc; logic [7:0] cl; logic ok;
    int d0; logic [7:0] c0; int prev_end; int bad_gap; int bad_byte;
    d0 = deq_cnt; c0 = sent_count_out; prev_end = 0; bad_gap = 0; bad_byte = 0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int i = 1; i <= 8; i++) begin
      rx_frame(-1, fr, st, sc, cl, ok);
      if (!ok || !st || fr[8:1] !== 8'(i)) begin
        bad_byte++;
        $display("FAIL b2b_byte index %0d got %h want %h", i, fr[8:1], 8'(i));
      end
      if (i > 1 && sc - prev_end != 2) bad_gap++;
      prev_end = cyc;
    end
    checks++; if (bad_byte != 0) begin errors++; $display("FAIL b2b_bytes bad %0d want 0", bad_byte); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_gap bad %0d want 0", bad_gap); end
    repeat (3) @(negedge clock);
    checks++; if (deq_cnt - d0 != 8) begin errors++; $display("FAIL b2b_deq_pulses got %0d want 8", deq_cnt - d0); end
    checks++; if (sent_count_out !== 8'(c0 + 8'd8)) begin errors++; $display("FAIL b2b_count got %0d want %0d", sent_count_out, c0 + 8'd8); end
    checks++; if (busy_out !== 1'b0 || len_in !== 8'd0) begin errors++; $display("FAIL b2b_idle busy %b len %0d want 0 0", busy_out, len_in); end
  endtask

  task automatic test_enable_drop();
    logic [10:0] fr; logic st; int sc; logic [7:0] cl; logic ok; int d0;
    d0 = deq_cnt;
    push(8'h11); push(8'h22); push(8'h33);
    rx_frame(2 * C, fr, st, sc, cl, ok);
    checks++; if (!ok || !st || fr[8:1] !== 8'h11) begin errors++; $display("FAIL drop_first_byte got %h want 11", fr[8:1]); end
    repeat (20) @(negedge clock);
    checks++; if (deq_cnt - d0 != 1) begin errors++; $display("FAIL drop_no_more_pops got %0d want 1", deq_cnt - d0); end
    checks++; if (busy_out !== 1'b0 || tx_out !== 1'b1 || len_in !== 8'd2) begin
      errors++; $display("FAIL drop_idle busy %b tx %b len %0d want 0 1 2", busy_out, tx_out, len_in);
    end
    enable_in = 1'b1;
    rx_frame(-1, fr, st, sc, cl, ok);
    checks++; if (!ok || !st || fr[8:1] !== 8'h22) begin errors++; $display("FAIL drop_resume_byte got %h want 22", fr[8:1]); end
    rx_frame(-1, fr, st, sc, cl, ok);
    checks++; if (!ok || !st || fr[8:1] !== 8'h33) begin errors++; $display("FAIL drop_third_byte got %h want 33", fr[8:1]); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] fr; logic st; int sc; logic [7:0] cl; logic ok;
    ok = 1'b0;
    push(8'h52); push(8'hC3);
    for (int t = 0; t < 200 && !ok; t++) begin
      if (tx_out === 1'b0) ok = 1'b1;
      else @(negedge clock);
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_start_timeout got %b want 1", ok); end
    repeat (C + 3 * C + 1) @(negedge clock);
    // 0x52 has bit 3 = 0, so the line is low just before reset
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL rstmid_bit3 got %b want 0", tx_out); end
    reset = 1'b0;
    #1;
    checks++; if (tx_out !== 1'b1 || sent_count_out !== 8'd0) begin
      errors++; $display("FAIL rstmid_async tx %b count %0d want 1 0", tx_out, sent_count_out);
    end
    checks++; if (busy_out !== 1'b0 || deq_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags busy %b deq %b want 0 0", busy_out, deq_out);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    rx_frame(-1, fr, st, sc, cl, ok);
    checks++; if (!ok || !st || fr[8:1] !== 8'hC3) begin errors++; $display("FAIL rstmid_next_byte got %h want c3", fr[8:1]); end
    repeat (2) @(negedge clock);
    checks++; if (sent_count_out !== 8'd1) begin errors++; $display("FAIL rstmid_count got %0d want 1", sent_count_out); end
    checks++; if (pop_empty != 0) begin errors++; $display("FAIL pop_empty got %0d want 0", pop_empty); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fila_serializer
`default_nettype wire
